bullet_pool: RTL and testbench

//  Parametrised multi-shot bullet engine for one player: manages NUM_BULLETS independent slots.

---
 rtl/bullet_pool.sv | 165 ++++++++++++++++
 tb/tb_bullet_pool.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - multi-slot bullet engine: edge-triggered fire, cooldown, per-slot flight and despawn
module bullet_pool #(
  parameter int NUM_BULLETS = 4,
  parameter int FIRE_KEY    = 44,
  parameter int STEP        = 12,
  parameter int BOOST       = 6,
  parameter int COOLDOWN    = 8,
  parameter int SIZE        = 2,
  parameter int X_MIN       = 1,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 1,
  parameter int Y_MAX       = 479
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [7:0]                keycode,
  input  logic [1:0]                direction,
  input  logic [9:0]                OriginX,
  input  logic [9:0]                OriginY,
  input  logic                      upgraded,
  input  logic [NUM_BULLETS-1:0]    kill,
  output logic [10*NUM_BULLETS-1:0] BulletX,
  output logic [10*NUM_BULLETS-1:0] BulletY,
  output logic [9:0]                BulletS,
  output logic [NUM_BULLETS-1:0]    bullet_on,
  output logic                      fire_pulse,
  output logic [2:0]                fire_slot
);

  // Wide enough to hold COOLDOWN itself, and at least one bit when COOLDOWN is 0.
  localparam int              CD_W     = $clog2(COOLDOWN + 2);
  localparam logic [CD_W-1:0] CD_MAX   = CD_W'(COOLDOWN);
  localparam logic [7:0]      FIRE_K   = 8'(FIRE_KEY);
  localparam logic [9:0]      STEP_W   = 10'(STEP);
  localparam logic [9:0]      BOOST_W  = 10'(BOOST);
  // Edge limits are precomputed so positions are only compared, never subtracted from.
  localparam logic [9:0]      X_HI     = 10'(X_MAX - SIZE);
  localparam logic [9:0]      X_LO     = 10'(X_MIN + SIZE);
  localparam logic [9:0]      Y_HI     = 10'(Y_MAX - SIZE);
  localparam logic [9:0]      Y_LO     = 10'(Y_MIN + SIZE);

  localparam logic [1:0] DIR_L = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_D = 2'b10;
  localparam logic [1:0] DIR_U = 2'b11;

  logic [NUM_BULLETS-1:0] on_q, on_d;
  logic [1:0]             dir_q [NUM_BULLETS];
  logic [1:0]             dir_d [NUM_BULLETS];
  logic [9:0]             x_q   [NUM_BULLETS];
  logic [9:0]             x_d   [NUM_BULLETS];
  logic [9:0]             y_q   [NUM_BULLETS];
  logic [9:0]             y_d   [NUM_BULLETS];
  logic                   released_q, released_d;
  logic [CD_W-1:0]        cooldown_q, cooldown_d;
  logic                   fire_pulse_q, fire_pulse_d;
  logic [2:0]             fire_slot_q, fire_slot_d;

  logic                   free_found;
  logic [2:0]             free_idx;
  logic                   fire_req;
  logic [9:0]             speed;

  // Next-state: slot allocation, per-slot kill/edge/move priority, fire bookkeeping.
  always_comb begin
    on_d         = on_q;
    dir_d        = dir_q;
    x_d          = x_q;
    y_d          = y_q;
    released_d   = (keycode != FIRE_K);
    cooldown_d   = cooldown_q;
    fire_pulse_d = 1'b0;
    fire_slot_d  = fire_slot_q;
    free_found   = 1'b0;
    free_idx     = 3'd0;
    speed        = STEP_W + (upgraded ? BOOST_W : 10'd0);

    // Lowest free slot; a slot despawning this edge still reads on_q=1, so it is not reused yet.
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!on_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end

    fire_req = (keycode == FIRE_K) && released_q && (cooldown_q == '0) && free_found;

    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (on_q[i]) begin
        if (kill[i]) begin
          on_d[i] = 1'b0;
        end else if ((x_q[i] >= X_HI) || (x_q[i] <= X_LO) ||
                     (y_q[i] >= Y_HI) || (y_q[i] <= Y_LO)) begin
          on_d[i] = 1'b0;
        end else begin
          // Modulo-1024 motion: underflow wraps high and trips the far-edge test next frame.
          case (dir_q[i])
            DIR_L:   x_d[i] = x_q[i] - speed;
            DIR_R:   x_d[i] = x_q[i] + speed;
            DIR_D:   y_d[i] = y_q[i] + speed;
            DIR_U:   y_d[i] = y_q[i] - speed;
            default: x_d[i] = x_q[i];
          endcase
        end
      end else begin
        // Idle slots follow the player so a fresh shot spawns from the current centre.
        x_d[i] = OriginX;
        y_d[i] = OriginY;
        if (fire_req && (free_idx == 3'(i))) begin
          on_d[i]  = 1'b1;
          dir_d[i] = direction;
        end
      end
    end

    if (fire_req) begin
      cooldown_d   = CD_MAX;
      fire_pulse_d = 1'b1;
      fire_slot_d  = free_idx;
    end else if (cooldown_q != '0) begin
      cooldown_d = cooldown_q - 1'b1;
    end
  end

  // State registers; Reset clears every slot immediately, even mid-flight.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      on_q         <= '0;
      released_q   <= 1'b1;
      cooldown_q   <= '0;
      fire_pulse_q <= 1'b0;
      fire_slot_q  <= 3'd0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        dir_q[i] <= 2'b00;
        x_q[i]   <= 10'd0;
        y_q[i]   <= 10'd0;
      end
    end else begin
      on_q         <= on_d;
      dir_q        <= dir_d;
      x_q          <= x_d;
      y_q          <= y_d;
      released_q   <= released_d;
      cooldown_q   <= cooldown_d;
      fire_pulse_q <= fire_pulse_d;
      fire_slot_q  <= fire_slot_d;
    end
  end

  // Pack per-slot positions onto the flat output buses.
  always_comb begin
    BulletX = '0;
    BulletY = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      BulletX[10*i +: 10] = x_q[i];
      BulletY[10*i +: 10] = y_q[i];
    end
  end

  assign BulletS    = 10'(SIZE);
  assign bullet_on  = on_q;
  assign fire_pulse = fire_pulse_q;
  assign fire_slot  = fire_slot_q;

endmodule

// File: tb/tb_bullet_pool.sv
// tb/tb_bullet_pool.sv - self-checking bench for bullet_pool with reference model and scoreboard
module tb_bullet_pool;

  logic        frame_clk;
  logic        Reset;
  logic [7:0]  keycode;
  logic [1:0]  direction;
  logic [9:0]  OriginX;
  logic [9:0]  OriginY;
  logic        upgraded;
  logic [3:0]  kill;
  logic [39:0] BulletX;
  logic [39:0] BulletY;
  logic [9:0]  BulletS;
  logic [3:0]  bullet_on;
  logic        fire_pulse;
  logic [2:0]  fire_slot;

  bullet_pool dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .direction (direction),
    .OriginX   (OriginX),
    .OriginY   (OriginY),
    .upgraded  (upgraded),
    .kill      (kill),
    .BulletX   (BulletX),
    .BulletY   (BulletY),
    .BulletS   (BulletS),
    .bullet_on (bullet_on),
    .fire_pulse(fire_pulse),
    .fire_slot (fire_slot)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [3:0]  on;
    logic [39:0] bx;
    logic [39:0] by;
    logic        pulse;
    logic [2:0]  slot;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int m_on[4];
  int m_dir[4];
  int m_x[4];
  int m_y[4];
  int m_rel, m_cd, m_pulse, m_slot;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_on[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_rel = 1; m_cd = 0; m_pulse = 0; m_slot = 0;
  endfunction

  function automatic void model_step();
    int d;
    int free;
    int fire;
    d = 12 + (upgraded ? 6 : 0);
    free = -1;
    for (int i = 3; i >= 0; i--) if (m_on[i] == 0) free = i;
    fire = (keycode == 8'd44 && m_rel == 1 && m_cd == 0 && free >= 0) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      if (m_on[i] == 1) begin
        if (kill[i]) m_on[i] = 0;
        else if (m_x[i] >= 637 || m_x[i] <= 3 || m_y[i] >= 477 || m_y[i] <= 3) m_on[i] = 0;
        else begin
          case (m_dir[i])
            0: m_x[i] = (m_x[i] - d) & 1023;
            1: m_x[i] = (m_x[i] + d) & 1023;
            2: m_y[i] = (m_y[i] + d) & 1023;
            default: m_y[i] = (m_y[i] - d) & 1023;
          endcase
        end
      end else begin
        m_x[i] = int'(OriginX);
        m_y[i] = int'(OriginY);
        if (fire == 1 && free == i) begin
          m_on[i] = 1;
          m_dir[i] = int'(direction);
        end
      end
    end
    m_rel = (keycode != 8'd44) ? 1 : 0;
    m_cd = (fire == 1) ? 8 : ((m_cd > 0) ? m_cd - 1 : 0);
    m_pulse = fire;
    if (fire == 1) m_slot = free;
  endfunction

  // Model the coming edge, queue the expectation, then compare after the edge.
  task automatic tick();
    exp_t e;
    exp_t g;
    model_step();
    for (int i = 0; i < 4; i++) begin
      e.on[i] = (m_on[i] == 1);
      e.bx[10*i +: 10] = 10'(m_x[i]);
      e.by[10*i +: 10] = 10'(m_y[i]);
    end
    e.pulse = (m_pulse == 1);
    e.slot = 3'(m_slot);
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 40'd1, 40'd0);
    end else begin
      g = sb.pop_front();
      chk("sb_on", 40'(bullet_on), 40'(g.on));
      chk("sb_x", BulletX, g.bx);
      chk("sb_y", BulletY, g.by);
      chk("sb_pulse", 40'(fire_pulse), 40'(g.pulse));
      chk("sb_slot", 40'(fire_slot), 40'(g.slot));
    end
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    #2;
    Reset = 1'b0;
  endtask

  int pulses;

  initial begin
    Reset = 1'b1; keycode = 8'd0; direction = 2'b01; OriginX = 10'd320; OriginY = 10'd240;
    upgraded = 1'b0; kill = 4'b0;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    chk("rst_on", 40'(bullet_on), 40'd0);
    chk("rst_x", BulletX, 40'd0);
    chk("rst_y", BulletY, 40'd0);
    chk("rst_pulse", 40'(fire_pulse), 40'd0);
    chk("rst_slot", 40'(fire_slot), 40'd0);
    chk("size", 40'(BulletS), 40'd2);
    Reset = 1'b0;

    // Idle slots track origin; single tap fires slot0 rightwards.
    tick();
    chk("track_x1", 40'(BulletX[19:10]), 40'd320);
    keycode = 8'd44; tick();
    chk("fire_pulse", 40'(fire_pulse), 40'd1);
    chk("fire_on", 40'(bullet_on), 40'd1);
    chk("fire_x0", 40'(BulletX[9:0]), 40'd320);
    keycode = 8'd0; tick();
    chk("move_x0_a", 40'(BulletX[9:0]), 40'd332);
    chk("pulse_drop", 40'(fire_pulse), 40'd0);
    tick();
    chk("move_x0_b", 40'(BulletX[9:0]), 40'd344);

    // Held key gives exactly one shot.
    do_reset();
    keycode = 8'd44; pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      pulses += int'(fire_pulse);
    end
    chk("hold_one_shot", 40'(pulses), 40'd1);
    keycode = 8'd0; tick();
    keycode = 8'd44; tick();
    chk("second_shot", 40'(fire_pulse), 40'd1);
    chk("second_slot", 40'(fire_slot), 40'd1);
    keycode = 8'd0; tick(); tick();
    keycode = 8'd44; tick();
    chk("cooldown_reject", 40'(fire_pulse), 40'd0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      pulses += int'(fire_pulse);
    end
    chk("reject_needs_release", 40'(pulses), 40'd0);
    keycode = 8'd0; tick();
    keycode = 8'd44; tick();
    chk("repress_fire", 40'(fire_pulse), 40'd1);
    keycode = 8'd0; tick();

    // Four spaced shots fill the pool; fifth press is refused; kill frees slot2.
    do_reset();
    OriginX = 10'd20; direction = 2'b01;
    for (int k = 0; k < 4; k++) begin
      keycode = 8'd44; tick();
      chk("fill_slot", 40'(fire_slot), 40'(k));
      keycode = 8'd0;
      repeat (9) tick();
    end
    chk("full_on", 40'(bullet_on), 40'hF);
    keycode = 8'd44; tick();
    chk("full_no_pulse", 40'(fire_pulse), 40'd0);
    chk("full_on_kept", 40'(bullet_on), 40'hF);
    keycode = 8'd0; kill = 4'b0100; tick();
    kill = 4'b0000;
    chk("kill_slot2", 40'(bullet_on), 40'hB);

    // Asynchronous reset with three shots in flight.
    Reset = 1'b1;
    #2;
    chk("async_rst_on", 40'(bullet_on), 40'd0);
    chk("async_rst_x", BulletX, 40'd0);
    chk("async_rst_y", BulletY, 40'd0);
    Reset = 1'b0;
    model_reset();
    tick();
    chk("post_rst_track", BulletX, {4{10'd20}});

    // Boosted upward shot.
    do_reset();
    OriginX = 10'd320; OriginY = 10'd240; direction = 2'b11; upgraded = 1'b1;
    keycode = 8'd44; tick();
    keycode = 8'd0; tick();
    chk("up_y_a", 40'(BulletY[9:0]), 40'd222);
    tick();
    chk("up_y_b", 40'(BulletY[9:0]), 40'd204);
    repeat (14) tick();
    chk("up_despawn", 40'(bullet_on[0]), 40'd0);

    // Leftward shot wraps below zero and despawns; freed slot is reusable.
    do_reset();
    OriginX = 10'd20; direction = 2'b00; upgraded = 1'b0;
    keycode = 8'd44; tick();
    keycode = 8'd0; tick();
    chk("left_x_a", 40'(BulletX[9:0]), 40'd8);
    tick();
    chk("left_wrap", 40'(BulletX[9:0]), 40'd1020);
    chk("left_still_on", 40'(bullet_on[0]), 40'd1);
    tick();
    chk("wrap_despawn", 40'(bullet_on[0]), 40'd0);
    tick();
    chk("freed_tracks", 40'(BulletX[9:0]), 40'd20);
    repeat (4) tick();
    keycode = 8'd44; tick();
    chk("reuse_pulse", 40'(fire_pulse), 40'd1);
    chk("reuse_slot", 40'(fire_slot), 40'd0);
    keycode = 8'd0; tick();

    chk("sb_drained", 40'(sb.size()), 40'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
